// File: rtl/ff_excite_driver.sv
// ff_excite_driver
// Drives a bank of W single-bit JK/SR flip-flops towards a requested target
// word. Each accepted transaction produces exactly one cycle of excitation,
// waits SETTLE_CYC cycles, reads the flip-flop Q vector back and reports the
// outcome. A shadow copy of the flip-flop state lets delta mode touch only the
// bits that actually need to change.
//
// Ports:
//   clk        rising-edge clock, shared with the driven flip-flops
//   rst_n      asynchronous active-low reset
//   in_valid   target word present
//   in_ready   high only while idle; a transfer happens when valid && ready
//   in_target  desired flip-flop state
//   in_mode    0 = force every bit, 1 = drive only the bits that differ
//   j, k       JK excitation (registered, non-zero only in the drive cycle)
//   s, r       SR excitation (registered, never both set on the same bit)
//   q_fb       flip-flop Q readback, synchronous to clk
//   done       one-cycle completion pulse
//   err        readback mismatch for the last transaction
//   mismatch   q_fb XOR target for the last transaction
//   err_cnt    saturating count of failed transactions
module ff_excite_driver #(
  parameter int W          = 4,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_target,
  input  logic             in_mode,
  output logic [W-1:0]     j,
  output logic [W-1:0]     k,
  output logic [W-1:0]     s,
  output logic [W-1:0]     r,
  input  logic [W-1:0]     q_fb,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYC);

  state_t         state;
  logic [3:0]     settle_cnt;
  logic [W-1:0]   shadow;
  logic [W-1:0]   target_l;

  logic [W-1:0]   flip;
  logic [W-1:0]   j_nx;
  logic [W-1:0]   k_nx;
  logic [W-1:0]   s_nx;
  logic [W-1:0]   r_nx;
  logic [W-1:0]   diff;

  // Error counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready = (state == IDLE);
  assign diff     = q_fb ^ target_l;

  // Excitation is computed from the live inputs and captured at the accept
  // edge, so the drive registers themselves hold the latched mode decision.
  // In delta mode S and R are gated by complementary target polarities, which
  // keeps S&R = 0 by construction; force mode uses target/~target likewise.
  always_comb begin
    flip = in_target ^ shadow;
    j_nx = in_target;
    k_nx = ~in_target;
    s_nx = in_target;
    r_nx = ~in_target;
    if (in_mode) begin
      j_nx = flip;
      k_nx = flip;
      s_nx = flip & in_target;
      r_nx = flip & ~in_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      shadow     <= '0;
      target_l   <= '0;
      j          <= '0;
      k          <= '0;
      s          <= '0;
      r          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      mismatch   <= '0;
      err_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // IDLE: wait for a target; excitation goes out on the next cycle
        IDLE: begin
          if (in_valid) begin
            target_l <= in_target;
            j        <= j_nx;
            k        <= k_nx;
            s        <= s_nx;
            r        <= r_nx;
            state    <= DRIVE;
          end
        end
        // DRIVE: the single excitation cycle; flip-flops update at its end
        DRIVE: begin
          j <= '0;
          k <= '0;
          s <= '0;
          r <= '0;
          if (SETTLE_CYC == 0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= SETTLE_L;
            state      <= SETTLE;
          end
        end
        // SETTLE: outputs idle for exactly SETTLE_CYC cycles
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            state <= CHECK;
          end
        end
        // CHECK: sample readback; shadow follows the real state even on error
        CHECK: begin
          mismatch <= diff;
          err      <= |diff;
          shadow   <= q_fb;
          if (|diff) begin
            err_cnt <= sat_inc(err_cnt);
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_excite_driver.sv
module tb_ff_excite_driver;

  localparam int S1 = 1;
  localparam int S2 = 0;
  localparam int P1 = 3 + S1;
  localparam int P2 = 3 + S2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // main instance: W=4, SETTLE_CYC=1, CNT_W=8
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [3:0] in_target = 4'd0;
  logic       in_ready, done, err;
  logic [3:0] j, k, s, r, mismatch, q_fb;
  logic [7:0] err_cnt;

  // second instance: SETTLE_CYC=0, CNT_W=2, readback tied by the bench
  logic       v2 = 1'b0;
  logic       md2 = 1'b0;
  logic [3:0] tgt2 = 4'd0;
  logic [3:0] q2 = 4'd0;
  logic       ready2, done2, err2;
  logic [3:0] j2, k2, s2, r2, mm2;
  logic [1:0] cnt2;

  ff_excite_driver #(.W(4), .SETTLE_CYC(S1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .in_mode(in_mode), .j(j), .k(k), .s(s), .r(r),
    .q_fb(q_fb), .done(done), .err(err), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  ff_excite_driver #(.W(4), .SETTLE_CYC(S2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ready2),
    .in_target(tgt2), .in_mode(md2), .j(j2), .k(k2), .s(s2), .r(r2),
    .q_fb(q2), .done(done2), .err(err2), .mismatch(mm2), .err_cnt(cnt2)
  );

  // Flip-flop bank model: JK characteristic Q+ = J&~Q | ~K&Q; a stuck bank
  // is held at zero.
  logic [3:0] q_model = 4'd0;
  logic       stuck = 1'b0;
  always @(posedge clk) begin
    if (stuck) q_model <= 4'd0;
    else       q_model <= (j & ~q_model) | (~k & q_model);
  end
  assign q_fb = q_model;

  always @(negedge clk) begin
    vectors++;
    if (((s & r) !== 4'd0) || ((s2 & r2) !== 4'd0)) begin
      miscompares++;
      $display("FAIL s_and_r: s=%b r=%b s2=%b r2=%b, required no common bit", s, r, s2, r2);
    end
  end

  // reference model state
  logic [3:0] sh_exp = 4'd0;
  int         cnt_exp = 0;

  task automatic run_txn(input logic [3:0] tgt, input logic md, input logic stk);
    logic [3:0] flip, ej, ek, es, er, q_exp;
    logic       e_err;
    int         n;
    bit         got;
    flip = tgt ^ sh_exp;
    if (md) begin
      ej = flip; ek = flip; es = flip & tgt; er = flip & ~tgt;
    end else begin
      ej = tgt; ek = ~tgt; es = tgt; er = ~tgt;
    end
    stuck = stk;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1; in_target = tgt; in_mode = md;
    @(negedge clk);
    in_valid = 1'b0; in_target = 4'($urandom); in_mode = 1'($urandom);
    vectors++;
    if ({j, k, s, r} !== {ej, ek, es, er}) begin
      miscompares++;
      $display("FAIL drive t=%b m=%b: jksr=%b %b %b %b, required %b %b %b %b",
               tgt, md, j, k, s, r, ej, ek, es, er);
    end
    n = 1; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1;
      else begin
        vectors++;
        if ({j, k, s, r} !== 16'd0 || in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL quiet cyc%0d: jksr=%b %b %b %b ready=%b, required 0 and ready 0",
                   n, j, k, s, r, in_ready);
        end
      end
    end
    vectors++;
    if (!got || n != P1) begin
      miscompares++;
      $display("FAIL done_latency: got=%0d cycle=%0d, required cycle %0d", got, n, P1);
    end
    q_exp = stk ? 4'd0 : tgt;
    e_err = (q_exp != tgt);
    if (e_err) cnt_exp = (cnt_exp < 255) ? cnt_exp + 1 : 255;
    vectors++;
    if (err !== e_err || mismatch !== (q_exp ^ tgt) || err_cnt !== 8'(cnt_exp) || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL result t=%b: err=%b mm=%b cnt=%0d ready=%b, required err=%b mm=%b cnt=%0d ready=1",
               tgt, err, mismatch, err_cnt, in_ready, e_err, q_exp ^ tgt, cnt_exp);
    end
    sh_exp = q_exp;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({j, k, s, r, mismatch} !== 20'd0 || done !== 1'b0 || err !== 1'b0 ||
        err_cnt !== 8'd0 || cnt2 !== 2'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: jksr=%b%b%b%b mm=%b done=%b err=%b cnt=%0d cnt2=%0d ready=%b, required zeros and ready 1",
               j, k, s, r, mismatch, done, err, err_cnt, cnt2, in_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // reset in the middle of the drive cycle
    @(negedge clk);
    in_valid = 1'b1; in_target = 4'b1010; in_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (j !== 4'b1010) begin
      miscompares++;
      $display("FAIL pre_reset_drive: j=%b, required 1010", j);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({j, k, s, r} !== 16'd0) begin
      miscompares++;
      $display("FAIL async_clear: jksr=%b %b %b %b, required all 0", j, k, s, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || done !== 1'b0 || err_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL post_reset c%0d: ready=%b done=%b cnt=%0d, required 1 0 0", c, in_ready, done, err_cnt);
      end
    end
    sh_exp = 4'd0; cnt_exp = 0;
    run_txn(4'b1010, 1'b1, 1'b0);
  endtask

  task automatic test_force();
    run_txn(4'b1010, 1'b0, 1'b0);
  endtask

  task automatic test_delta();
    run_txn(4'b0110, 1'b1, 1'b0);
  endtask

  task automatic test_stuck();
    run_txn(4'b0011, 1'b0, 1'b1);
    run_txn(4'b0001, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] tl [3];
    int acc[$];
    int dn[$];
    int nacc;
    tl[0] = 4'b0001; tl[1] = 4'b0010; tl[2] = 4'b0011;
    nacc = 0;
    in_mode = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dn.push_back(c);
        vectors++;
        if (err !== 1'b0 || mismatch !== 4'd0) begin
          miscompares++;
          $display("FAIL b2b_result c%0d: err=%b mm=%b, required 0 0000", c, err, mismatch);
        end
      end
      if (in_ready === 1'b1) begin
        if (nacc < 3) begin
          in_valid = 1'b1; in_target = tl[nacc]; acc.push_back(c); nacc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (acc.size() != 3 || acc[0] != 0 || acc[1] != P1 || acc[2] != 2 * P1) begin
      miscompares++;
      $display("FAIL b2b_accepts: n=%0d first=%0d,%0d,%0d, required 0,%0d,%0d",
               acc.size(), acc.size() > 0 ? acc[0] : -1, acc.size() > 1 ? acc[1] : -1,
               acc.size() > 2 ? acc[2] : -1, P1, 2 * P1);
    end
    vectors++;
    if (dn.size() != 3 || dn[0] != P1 || dn[1] != 2 * P1 || dn[2] != 3 * P1) begin
      miscompares++;
      $display("FAIL b2b_dones: n=%0d, required 3 pulses at %0d,%0d,%0d", dn.size(), P1, 2 * P1, 3 * P1);
    end
    sh_exp = 4'b0011;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_txn(4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    stuck = 1'b0;
  endtask

  task automatic test_settle0_sat();
    logic [3:0] t;
    int         n;
    int         ecnt;
    bit         got;
    ecnt = 0;
    q2 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      t = 4'($urandom_range(1, 15));
      @(negedge clk);
      v2 = 1'b1; tgt2 = t; md2 = 1'b0;
      @(negedge clk);
      v2 = 1'b0; tgt2 = 4'($urandom);
      vectors++;
      if (j2 !== t || k2 !== ~t) begin
        miscompares++;
        $display("FAIL s0_drive: j=%b k=%b, required %b %b", j2, k2, t, ~t);
      end
      n = 1; got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (done2 === 1'b1) got = 1;
      end
      ecnt = (ecnt < 3) ? ecnt + 1 : 3;
      vectors++;
      if (!got || n != P2 || err2 !== 1'b1 || mm2 !== t || cnt2 !== 2'(ecnt) || ready2 !== 1'b1) begin
        miscompares++;
        $display("FAIL s0_sat #%0d: got=%0d cyc=%0d err=%b mm=%b cnt=%0d ready=%b, required cyc %0d err 1 mm %b cnt %0d ready 1",
                 i, got, n, err2, mm2, cnt2, ready2, P2, t, ecnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_force();
    test_delta();
    test_stuck();
    test_back_to_back();
    test_random();
    test_settle0_sat();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ff_excite_driver.md
Name: ff_excite_driver

Overview:
- Upstream stage for a bank of W single-bit JK/SR flip-flops.
- Accepts a target word over a valid/ready handshake and converts it into one cycle of J/K and S/R excitation.
- Waits a programmable settle time, then reads back the flip-flop Q vector.
- Reports done, error, a per-bit mismatch vector and a saturating error count. Keeps a shadow copy of the expected flip-flop state.

Parameters:
- W, 4, number of flip-flops driven (1..32).
- SETTLE_CYC, 1, cycles between the drive pulse and readback (0..15).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock, shared with the driven flip-flops
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  target word present
- in_ready  out  1  block idle and able to accept
- in_target  in  W  desired flip-flop state
- in_mode  in  1  0 = force mode, 1 = delta mode
- j  out  W  JK J drive
- k  out  W  JK K drive
- s  out  W  SR S drive
- r  out  W  SR R drive
- q_fb  in  W  flip-flop Q readback
- done  out  1  one-cycle completion pulse
- err  out  1  readback mismatch for the last transaction
- mismatch  out  W  q_fb XOR target for the last transaction
- err_cnt  out  CNT_W  saturating count of failed transactions

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; j, k, s, r = 0; done = 0; err = 0; mismatch = 0; err_cnt = 0; shadow = 0; latched target/mode = 0.
- Reset mid-transaction: takes effect immediately, with no completion pulse. After release, in_ready = 1.
- in_ready = 1 only in IDLE, decoded from registered state.
- Handshake: a transaction is accepted on a rising edge where in_valid and in_ready are both 1. in_target and in_mode are latched at that edge. in_valid held low means the block stays in IDLE.
- State machine: IDLE -> DRIVE -> SETTLE (SETTLE_CYC cycles; skipped when SETTLE_CYC = 0) -> CHECK -> IDLE.
- DRIVE (exactly one cycle, registered outputs):
  - flip = target XOR shadow.
  - Force mode: j = target, k = ~target, s = target, r = ~target on all bits.
  - Delta mode: j = k = flip (toggle); s = flip AND target; r = flip AND ~target; non-flipping bits get 00 (hold).
- Outside DRIVE, j, k, s and r are all 0.
- Invariant: s AND r = 0 on every bit, every cycle.
- SETTLE: outputs at zero; a down-counter is loaded with SETTLE_CYC at DRIVE exit.
- CHECK (one cycle): q_fb is sampled at the end of the cycle.
  - mismatch <= q_fb XOR target.
  - err <= (mismatch != 0).
  - shadow <= q_fb, which resynchronises to the real state even on error.
  - err_cnt increments when err is set and saturates at 2^CNT_W - 1.
- done is high for exactly the first IDLE cycle after CHECK. err and mismatch hold their value until the next CHECK.
- Timing: accept at edge of cycle 0, DRIVE in cycle 1, done in cycle 3+SETTLE_CYC. That same cycle has in_ready = 1, so back-to-back throughput is one transaction per 3+SETTLE_CYC cycles.
- in_valid/in_target changes outside IDLE are ignored.
- q_fb is assumed synchronous to clk; no synchroniser is included.

Test Plan (W=4, SETTLE_CYC=1, bench flip-flop model attached unless stated):
1. Reset mid-DRIVE: rst_n low during the cycle where j=1010 -> j/k/s/r go to 0000 without a clock edge. After release, in_ready=1, done=0, err_cnt=0; the next delta transaction uses shadow=0000.
2. Force mode, target 1010 from reset, accept at cycle 0 -> cycle 1: j=1010, k=0101, s=1010, r=0101; cycle 4: done=1, err=0, mismatch=0000, in_ready=1.
3. Delta mode, shadow 1010, target 0110 -> flip=1100: j=k=1100, s=0100, r=1000; bits [1:0] driven 00. q_fb ends at 0110 and err=0.
4. Stuck flip-flop: q_fb forced to 0000, force-mode target 0011 -> done with err=1, mismatch=0011, err_cnt 0 to 1, shadow=0000. A following delta target 0001 drives only bit 0.
5. in_valid held high with targets 0001, 0010, 0011 -> accepts at cycles 0, 4 and 8; three done pulses; s AND r = 0 checked every cycle.
6. SETTLE_CYC=0 build: done at cycle 3. CNT_W=2 with five failed transactions -> err_cnt saturates at 3.
